// File: rtl/onehot_decoder_hold_if.sv
// Handshake and decoded-strobe bundle for onehot_decoder_hold.
interface onehot_decoder_hold_if;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic [7:0] y;
  logic       active;
  logic       done;

  // Code source side: drives the index and enable, observes the strobe.
  modport master (
    output en, in_valid, code,
    input  in_ready, y, active, done
  );

  // Decoder side.
  modport slave (
    input  en, in_valid, code,
    output in_ready, y, active, done
  );
endinterface

// File: rtl/onehot_decoder_hold.sv
// onehot_decoder_hold: turns a 3-bit index into an 8-line one-hot strobe held
// for HOLD_CYCLES cycles, then pulses done. Define SEG7_DISP_EN to add a
// registered active-low seven-segment view (led, g..a) of the last latched code.
module onehot_decoder_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  onehot_decoder_hold_if.slave      bus
`ifdef SEG7_DISP_EN
  ,
  output logic [6:0]                led
`endif
);

  localparam int unsigned Y_W    = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              accept;

  assign accept       = bus.in_valid && (state_q == IDLE);
  assign bus.in_ready = (state_q == IDLE);
  assign bus.y        = y_q;
  assign bus.active   = active_q;
  assign bus.done     = done_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    y_d      = y_q;
    active_d = active_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          code_d = bus.code;
          if (bus.en) begin
            y_d      = Y_W'(1) << bus.code;
            active_d = 1'b1;
            cnt_d    = CNT_W'(HOLD_CYCLES - 1);
            state_d  = HOLD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!bus.en) begin
          // Abort: drop the strobe silently, no completion pulse.
          y_d      = '0;
          active_d = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == '0) begin
          y_d      = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          y_d   = Y_W'(1) << code_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      y_q      <= y_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

`ifdef SEG7_DISP_EN
  logic [6:0] led_d;

  // Segment pattern (g..a, active-low) for the incoming code on accept.
  always_comb begin
    led_d = led;
    if (accept) begin
      unique case (bus.code)
        3'd0: led_d = 7'b1000000;
        3'd1: led_d = 7'b1111001;
        3'd2: led_d = 7'b0100100;
        3'd3: led_d = 7'b0110000;
        3'd4: led_d = 7'b0011001;
        3'd5: led_d = 7'b0010010;
        3'd6: led_d = 7'b0000010;
        3'd7: led_d = 7'b1111000;
        default: led_d = 7'b1000000;
      endcase
    end
  end

  // Display register, shows code 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) led <= 7'b1000000;
    else     led <= led_d;
  end
`endif

endmodule
